// File: rtl/spike_rate_decoder.sv
// Spike-count readout: counts per-channel spikes over a window of enabled cycles,
// then holds the latched counts, argmax winner and overflow behind a valid/ready handshake.
module spike_rate_decoder #(
    parameter int NUM_CH = 3,
    parameter int CNT_W  = 8,
    parameter int WIN_W  = 8,
    localparam int IDX_W = $clog2(NUM_CH)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    enable,
    input  logic [NUM_CH-1:0]       spike_in,
    input  logic [WIN_W-1:0]        window_len,
    input  logic                    start,
    input  logic                    out_ready,
    output logic                    out_valid,
    output logic [NUM_CH*CNT_W-1:0] counts,
    output logic [IDX_W-1:0]        winner,
    output logic                    overflow,
    output logic                    busy
);

    typedef enum logic [1:0] {
        IDLE,
        COUNT,
        HOLD
    } state_t;

    state_t state, state_next;

    logic [CNT_W-1:0] cnt      [NUM_CH];
    logic [CNT_W-1:0] cnt_next [NUM_CH];
    logic [NUM_CH-1:0] sat, sat_next;
    logic [WIN_W-1:0] win_cnt;
    logic [IDX_W-1:0] best_idx;
    logic [CNT_W-1:0] best_cnt;
    logic [NUM_CH*CNT_W-1:0] packed_next;

    logic start_ok;
    logic last_sample;

    assign start_ok    = start && (window_len != '0);
    assign last_sample = enable && (win_cnt == WIN_W'(1));

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start_ok) state_next = COUNT;
            COUNT:   if (last_sample) state_next = HOLD;
            HOLD:    if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Counter values after this cycle's spikes, so the final sample is included in the latch.
    always_comb begin
        sat_next = sat;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            cnt_next[i] = cnt[i];
            if (spike_in[i]) begin
                if (cnt[i] == '1) sat_next[i] = 1'b1;
                else              cnt_next[i] = cnt[i] + CNT_W'(1);
            end
        end
    end

    // Strict greater-than keeps the lowest index on ties.
    always_comb begin
        best_idx    = '0;
        best_cnt    = cnt_next[0];
        packed_next = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            packed_next[i*CNT_W +: CNT_W] = cnt_next[i];
            if (cnt_next[i] > best_cnt) begin
                best_cnt = cnt_next[i];
                best_idx = IDX_W'(i);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            sat      <= '0;
            win_cnt  <= '0;
            counts   <= '0;
            winner   <= '0;
            overflow <= 1'b0;
            for (int unsigned i = 0; i < NUM_CH; i++) cnt[i] <= '0;
        end else begin
            state <= state_next;
            case (state)
                IDLE: begin
                    if (start_ok) begin
                        sat     <= '0;
                        win_cnt <= window_len;
                        for (int unsigned i = 0; i < NUM_CH; i++) cnt[i] <= '0;
                    end
                end
                COUNT: begin
                    if (enable) begin
                        sat     <= sat_next;
                        win_cnt <= win_cnt - WIN_W'(1);
                        for (int unsigned i = 0; i < NUM_CH; i++) cnt[i] <= cnt_next[i];
                        if (last_sample) begin
                            counts   <= packed_next;
                            winner   <= best_idx;
                            overflow <= |sat_next;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign out_valid = (state == HOLD);
    assign busy      = (state != IDLE);

endmodule

// File: tb/tb_spike_rate_decoder.sv
// Directed bench for spike_rate_decoder: default instance plus a CNT_W=4 instance driven in
// lockstep, checked every cycle against a raw-count model and pinned by literal expectations.
module tb_spike_rate_decoder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        enable;
    logic [2:0]  spike_in;
    logic [7:0]  window_len;
    logic        start;
    logic        out_ready;

    logic        out_valid_a, overflow_a, busy_a;
    logic [23:0] counts_a;
    logic [1:0]  winner_a;
    logic        out_valid_b, overflow_b, busy_b;
    logic [11:0] counts_b;
    logic [1:0]  winner_b;

    int tests = 0;
    int fails = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    spike_rate_decoder dut_a (
        .clk(clk), .rst_n(rst_n), .enable(enable), .spike_in(spike_in),
        .window_len(window_len), .start(start), .out_ready(out_ready),
        .out_valid(out_valid_a), .counts(counts_a), .winner(winner_a),
        .overflow(overflow_a), .busy(busy_a)
    );

    spike_rate_decoder #(.CNT_W(4)) dut_b (
        .clk(clk), .rst_n(rst_n), .enable(enable), .spike_in(spike_in),
        .window_len(window_len), .start(start), .out_ready(out_ready),
        .out_valid(out_valid_b), .counts(counts_b), .winner(winner_b),
        .overflow(overflow_b), .busy(busy_b)
    );

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: unbounded raw spike tallies; saturation and overflow derived by clamping.
    int m_mode [2];          // 0 idle, 1 counting, 2 holding
    int m_rem  [2];
    int raw    [2][3];
    int e_cnt  [2][3];
    int e_win  [2];
    int e_ovf  [2];
    int cmax   [2] = '{255, 15};

    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (!rst_n) begin
                m_mode[k] = 0; m_rem[k] = 0; e_win[k] = 0; e_ovf[k] = 0;
                for (int i = 0; i < 3; i++) begin raw[k][i] = 0; e_cnt[k][i] = 0; end
            end else if (m_mode[k] == 0) begin
                if (start && window_len != 0) begin
                    m_mode[k] = 1;
                    m_rem[k]  = window_len;
                    for (int i = 0; i < 3; i++) raw[k][i] = 0;
                end
            end else if (m_mode[k] == 1) begin
                if (enable) begin
                    for (int i = 0; i < 3; i++) raw[k][i] += spike_in[i];
                    m_rem[k]--;
                    if (m_rem[k] == 0) begin
                        m_mode[k] = 2;
                        e_ovf[k]  = 0;
                        e_win[k]  = 0;
                        for (int i = 0; i < 3; i++) begin
                            e_cnt[k][i] = (raw[k][i] > cmax[k]) ? cmax[k] : raw[k][i];
                            if (raw[k][i] > cmax[k]) e_ovf[k] = 1;
                        end
                        for (int i = 1; i < 3; i++)
                            if (e_cnt[k][i] > e_cnt[k][e_win[k]]) e_win[k] = i;
                    end
                end
            end else if (out_ready) begin
                m_mode[k] = 0;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("valid_a", out_valid_a, m_mode[0] == 2);
            chk("busy_a", busy_a, m_mode[0] != 0);
            chk("winner_a", winner_a, e_win[0]);
            chk("ovf_a", overflow_a, e_ovf[0]);
            chk("valid_b", out_valid_b, m_mode[1] == 2);
            chk("busy_b", busy_b, m_mode[1] != 0);
            chk("winner_b", winner_b, e_win[1]);
            chk("ovf_b", overflow_b, e_ovf[1]);
            for (int i = 0; i < 3; i++) begin
                chk("cnt_a", counts_a[i*8 +: 8], e_cnt[0][i]);
                chk("cnt_b", counts_b[i*4 +: 4], e_cnt[1][i]);
            end
        end
    end

    task automatic wait_valid(input int limit, output int cycles);
        cycles = 0;
        while (!out_valid_a && cycles < limit) begin
            @(negedge clk);
            cycles++;
        end
        if (!out_valid_a) begin
            tests++;
            fails++;
            $display("FAIL wait_valid: timeout after %0d cycles", limit);
        end
    endtask

    task automatic release_result();
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    initial begin
        int n;
        rst_n = 1'b0; enable = 1'b0; spike_in = 3'b111; window_len = 8'd4;
        start = 1'b1; out_ready = 1'b0;

        // 1: reset dominates start/spikes
        @(negedge clk);
        chk_en = 1'b1;
        @(negedge clk);
        chk("rst_valid", out_valid_a, 0);
        chk("rst_busy", busy_a, 0);
        chk("rst_counts", counts_a, 0);
        start = 1'b0; rst_n = 1'b1; spike_in = 3'b000;
        @(negedge clk);

        // 2: 4-sample window, tie resolves to ch0; window_len change mid-window ignored
        window_len = 8'd4; start = 1'b1; enable = 1'b1; spike_in = 3'b101;
        @(negedge clk);
        start = 1'b0; window_len = 8'd9;
        wait_valid(20, n);
        chk("t2_latency", n, 4);
        chk("t2_ch0", counts_a[7:0], 4);
        chk("t2_ch1", counts_a[15:8], 0);
        chk("t2_ch2", counts_a[23:16], 4);
        chk("t2_winner", winner_a, 0);
        chk("t2_ovf", overflow_a, 0);
        release_result();

        // 3: gated enable 1,0,1,0,1 with window 3
        window_len = 8'd3; start = 1'b1; enable = 1'b0; spike_in = 3'b010;
        @(negedge clk);
        start = 1'b0;
        enable = 1'b1; @(negedge clk);
        enable = 1'b0; @(negedge clk);
        enable = 1'b1; @(negedge clk);
        enable = 1'b0; @(negedge clk);
        enable = 1'b1; @(negedge clk);
        enable = 1'b0;
        chk("t3_valid", out_valid_a, 1);
        chk("t3_ch1", counts_a[15:8], 3);
        chk("t3_ch0", counts_a[7:0], 0);
        chk("t3_winner", winner_a, 1);
        release_result();

        // 4: 20 samples; the 4-bit instance saturates at 15
        window_len = 8'd20; start = 1'b1; enable = 1'b1; spike_in = 3'b010;
        @(negedge clk);
        start = 1'b0;
        wait_valid(50, n);
        chk("t4_latency", n, 20);
        chk("t4_b_ch1", counts_b[7:4], 15);
        chk("t4_b_ovf", overflow_b, 1);
        chk("t4_b_winner", winner_b, 1);
        chk("t4_a_ch1", counts_a[15:8], 20);
        chk("t4_a_ovf", overflow_a, 0);

        // 5: long hold with start pulse, then accept
        for (int c = 0; c < 10; c++) begin
            start = (c == 3);
            window_len = 8'd2;
            @(negedge clk);
        end
        start = 1'b0;
        chk("t5_valid", out_valid_b, 1);
        chk("t5_busy", busy_b, 1);
        chk("t5_ch1", counts_b[7:4], 15);
        release_result();
        chk("t5_valid_drop", out_valid_a, 0);
        chk("t5_busy_drop", busy_a, 0);
        chk("t5_keep", counts_a[15:8], 20);

        // 6: zero-length start ignored; reset aborts a window
        window_len = 8'd0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("t6_zero_busy", busy_a, 0);
        window_len = 8'd5; start = 1'b1; enable = 1'b1; spike_in = 3'b111;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("t6_rst_busy", busy_a, 0);
        chk("t6_rst_counts", counts_a, 0);
        window_len = 8'd2; start = 1'b1; spike_in = 3'b001;
        @(negedge clk);
        start = 1'b0;
        wait_valid(20, n);
        chk("t6_latency", n, 2);
        chk("t6_ch0", counts_a[7:0], 2);
        chk("t6_ch1", counts_a[15:8], 0);
        chk("t6_ch2", counts_a[23:16], 0);
        chk("t6_winner", winner_a, 0);
        release_result();
        @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
